// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding, default geometry and address field extraction
// for the direct-mapped read cache.
package cache_pkg;
   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, RESP, FLUSH} state_t;
   localparam int ADDR_W_DEF   = 15;
   localparam int WORD_W_DEF   = 32;
   localparam int INDEX_W_DEF  = 10;
   localparam int OFFSET_W_DEF = 2;
   localparam int CNT_W_DEF    = 32;
   function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb, input int width);
      return (addr >> lsb) & ~(32'hFFFF_FFFF << width);
   endfunction
endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: tag/data arrays with a resettable valid vector, clear-all,
// single-line write and a registered read port.
module cache_line_store #(
   parameter int TAG_W   = 3,
   parameter int INDEX_W = 10,
   parameter int LINE_W  = 128
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clr,
   input  logic               i_rd_en,
   input  logic [INDEX_W-1:0] i_rd_idx,
   input  logic               i_wr_en,
   input  logic [INDEX_W-1:0] i_wr_idx,
   input  logic [TAG_W-1:0]   i_wr_tag,
   input  logic [LINE_W-1:0]  i_wr_line,
   output logic               o_rd_valid,
   output logic [TAG_W-1:0]   o_rd_tag,
   output logic [LINE_W-1:0]  o_rd_line
);
   logic [TAG_W-1:0]      r_tag  [2**INDEX_W];
   logic [LINE_W-1:0]     r_line [2**INDEX_W];
   logic [2**INDEX_W-1:0] r_valid;
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_tag[i_wr_idx]  <= i_wr_tag;
         r_line[i_wr_idx] <= i_wr_line;
      end
      if (i_rd_en) begin
         o_rd_tag  <= r_tag[i_rd_idx];
         o_rd_line <= r_line[i_rd_idx];
      end
   end
   always_ff @(posedge clk) begin
      if (rst || i_clr) r_valid <= '0;
      else if (i_wr_en) r_valid[i_wr_idx] <= 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) o_rd_valid <= 1'b0;
      else if (i_rd_en) o_rd_valid <= r_valid[i_rd_idx];
   end
endmodule

// File: rtl/cache_read_ctrl.sv
// cache_read_ctrl: direct-mapped read cache with request/response handshake,
// multi-cycle line fill, flush and saturating hit/miss counters.
module cache_read_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int WORD_W   = WORD_W_DEF,
   parameter int INDEX_W  = INDEX_W_DEF,
   parameter int OFFSET_W = OFFSET_W_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid,
   input  logic [ADDR_W-1:0]              req_addr,
   output logic                           req_ready,
   input  logic                           flush,
   output logic                           resp_valid,
   output logic [WORD_W-1:0]              resp_data,
   output logic                           resp_hit,
   output logic                           mem_req,
   output logic [ADDR_W-OFFSET_W-1:0]     mem_line_addr,
   input  logic                           mem_valid,
   input  logic [WORD_W*(2**OFFSET_W)-1:0] mem_line,
   output logic [CNT_W-1:0]               hit_count,
   output logic [CNT_W-1:0]               miss_count
);
   localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINE_W = WORD_W * (2**OFFSET_W);
   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [WORD_W-1:0]   r_resp_data;
   logic                r_resp_hit;
   logic [CNT_W-1:0]    r_hit_cnt, r_miss_cnt;
   logic [TAG_W-1:0]    w_tag, w_rd_tag;
   logic [INDEX_W-1:0]  w_idx, w_req_idx;
   logic [OFFSET_W-1:0] w_off;
   logic [LINE_W-1:0]   w_rd_line, w_sel_line;
   logic [WORD_W-1:0]   w_word;
   logic                w_rd_valid, w_accept, w_hit, w_lookup_hit, w_lookup_miss, w_fill_done;
   assign w_tag         = TAG_W'(addr_field(32'(r_addr), INDEX_W + OFFSET_W, TAG_W));
   assign w_idx         = INDEX_W'(addr_field(32'(r_addr), OFFSET_W, INDEX_W));
   assign w_off         = OFFSET_W'(addr_field(32'(r_addr), 0, OFFSET_W));
   assign w_req_idx     = INDEX_W'(addr_field(32'(req_addr), OFFSET_W, INDEX_W));
   assign w_accept      = req_valid && req_ready;
   assign w_hit         = w_rd_valid && (w_rd_tag == w_tag);
   assign w_lookup_hit  = (r_state == LOOKUP) && w_hit;
   assign w_lookup_miss = (r_state == LOOKUP) && !w_hit;
   assign w_fill_done   = (r_state == FILL) && mem_valid;
   // In FILL the word is taken straight from the arriving line rather than the store.
   assign w_sel_line    = (r_state == FILL) ? mem_line : w_rd_line;
   assign w_word        = WORD_W'(w_sel_line >> (int'(w_off) * WORD_W));
   cache_line_store #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .LINE_W(LINE_W)) u_store (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (r_state == FLUSH),
      .i_rd_en    (w_accept),
      .i_rd_idx   (w_req_idx),
      .i_wr_en    (w_fill_done && !rst),
      .i_wr_idx   (w_idx),
      .i_wr_tag   (w_tag),
      .i_wr_line  (mem_line),
      .o_rd_valid (w_rd_valid),
      .o_rd_tag   (w_rd_tag),
      .o_rd_line  (w_rd_line)
   );
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      mem_req     = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready   = !flush;
            w_state_nxt = flush ? FLUSH : (req_valid ? LOOKUP : IDLE);
         end
         LOOKUP: w_state_nxt = w_hit ? RESP : FILL;
         FILL: begin
            mem_req     = 1'b1;
            w_state_nxt = mem_valid ? RESP : FILL;
         end
         RESP: begin
            resp_valid  = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_resp_data <= '0;
         r_resp_hit  <= 1'b0;
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) r_addr <= req_addr;
         if (w_lookup_hit || w_fill_done) begin
            r_resp_data <= w_word;
            r_resp_hit  <= w_lookup_hit;
         end
         if (w_lookup_hit && r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
         if (w_lookup_miss && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
      end
   end
   assign resp_data     = r_resp_data;
   assign resp_hit      = r_resp_hit;
   assign mem_line_addr = r_addr[ADDR_W-1:OFFSET_W];
   assign hit_count     = r_hit_cnt;
   assign miss_count    = r_miss_cnt;
endmodule

// File: tb/tb_cache_read_ctrl.sv
// tb_cache_read_ctrl: directed and randomized requests against an array-based
// reference cache (CNT_W=4 so counter saturation is reachable).
module tb_cache_read_ctrl;
   logic         clk = 0, rst = 1, req_valid = 0, flush = 0, mem_valid = 0;
   logic [14:0]  req_addr = '0;
   logic [127:0] mem_line = '0;
   logic         req_ready, resp_valid, resp_hit, mem_req;
   logic [31:0]  resp_data;
   logic [12:0]  mem_line_addr;
   logic [3:0]   hit_count, miss_count;
   int           n_vec = 0, n_err = 0;
   bit           mv [1024];
   logic [2:0]   mt [1024];
   logic [127:0] ml [1024];
   int           m_hits = 0, m_miss = 0;

   always #5 clk = ~clk;

   cache_read_ctrl #(.CNT_W(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .flush(flush), .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
      .mem_req(mem_req), .mem_line_addr(mem_line_addr), .mem_valid(mem_valid), .mem_line(mem_line),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      return v > 15 ? 15 : v;
   endfunction

   task automatic model_clear();
      foreach (mv[i]) mv[i] = 0;
   endtask

   task automatic wait_ready();
      int w = 0;
      @(negedge clk);
      while (!req_ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      chk("req_ready", req_ready, 1);
   endtask

   task automatic chk_counts();
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_miss);
   endtask

   task automatic do_req(input logic [14:0] a, input int dly, input logic [127:0] line);
      logic [9:0]   idx;
      logic [2:0]   tg;
      logic [127:0] eline;
      logic [31:0]  eword;
      int           off, k, nf, mv_edge;
      bit           hit, seen, mla_done;
      idx = a[11:2];
      tg = a[14:12];
      off = int'(a[1:0]);
      hit = mv[idx] && (mt[idx] == tg);
      eline = hit ? ml[idx] : line;
      eword = eline[off*32 +: 32];
      wait_ready();
      req_valid = 1;
      req_addr = a;
      @(posedge clk);
      #1 req_valid = 0;
      k = 0; nf = 0; mv_edge = -1; seen = 0; mla_done = 0;
      while (!seen && k < 40) begin
         @(negedge clk);
         if (mem_req) begin
            if (hit) chk("mem_req_on_hit", mem_req, 0);
            else if (!mla_done) begin
               chk("mem_line_addr", mem_line_addr, a[14:2]);
               mla_done = 1;
            end
            if (nf == dly) begin
               mem_valid = 1;
               mem_line = line;
               mv_edge = k + 1;
            end
            nf++;
         end else begin
            mem_valid = ($urandom_range(0, 3) == 0);
            mem_line = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         @(posedge clk);
         k++;
         #1 mem_valid = 0;
         seen = resp_valid;
      end
      chk("resp_valid", seen, 1);
      chk("latency", k + 1, hit ? 2 : mv_edge + 1);
      chk("resp_hit", resp_hit, hit);
      chk("resp_data", resp_data, eword);
      if (hit) m_hits = sat(m_hits + 1);
      else begin
         m_miss = sat(m_miss + 1);
         mv[idx] = 1;
         mt[idx] = tg;
         ml[idx] = line;
      end
      chk_counts();
      @(posedge clk);
      #1;
      chk("resp_pulse", resp_valid, 0);
      chk("resp_hold", resp_data, eword);
   endtask

   task automatic do_flush(input bit with_req, input logic [14:0] a);
      wait_ready();
      flush = 1;
      req_valid = with_req;
      req_addr = a;
      #1 chk("ready_while_flush", req_ready, 0);
      @(posedge clk);
      #1 flush = 0;
      req_valid = 0;
      chk("flush_busy", req_ready, 0);
      @(posedge clk);
      #1;
      chk("flush_done_ready", req_ready, 1);
      chk("flush_no_resp", resp_valid, 0);
      chk_counts();
      model_clear();
   endtask

   task automatic do_rst_in_fill(input logic [14:0] a);
      int  w = 0;
      bit  any = 0;
      wait_ready();
      req_valid = 1;
      req_addr = a;
      @(posedge clk);
      #1 req_valid = 0;
      @(negedge clk);
      while (!mem_req && w < 5) begin
         @(negedge clk);
         w++;
      end
      chk("fill_reached", mem_req, 1);
      rst = 1;
      @(posedge clk);
      #1 chk("mem_req_after_rst", mem_req, 0);
      @(negedge clk);
      rst = 0;
      mem_valid = 1;
      mem_line = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk);
      #1 mem_valid = 0;
      for (int i = 0; i < 4; i++) begin
         any |= resp_valid;
         @(posedge clk);
         #1;
      end
      chk("late_mem_valid_resp", any, 0);
      model_clear();
      m_hits = 0;
      m_miss = 0;
      chk_counts();
   endtask

   function automatic logic [14:0] rand_addr();
      logic [9:0] idx;
      case ($urandom_range(0, 2))
         0: idx = 10'h08D;
         1: idx = 10'h08E;
         default: idx = 10'h3FF;
      endcase
      return {3'($urandom_range(0, 7)), idx, 2'($urandom_range(0, 3))};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 0;
      #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_hit", resp_hit, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_line_addr", mem_line_addr, 0);
      chk_counts();
      do_req(15'h1234, 3, {32'hD, 32'hC, 32'hB, 32'hA});
      do_req(15'h1236, 0, {$urandom(), $urandom(), $urandom(), $urandom()});
      do_req(15'h5234, 1, {$urandom(), $urandom(), $urandom(), $urandom()});
      do_req(15'h1234, 0, {$urandom(), $urandom(), $urandom(), $urandom()});
      do_flush(0, 15'h0);
      do_req(15'h5234, 2, {$urandom(), $urandom(), $urandom(), $urandom()});
      do_flush(1, 15'h5234);
      do_req(15'h5234, 0, {$urandom(), $urandom(), $urandom(), $urandom()});
      repeat (16) do_req(15'h5235, 0, 128'h0);
      do_rst_in_fill(15'h7000);
      do_req(15'h7000, 1, {$urandom(), $urandom(), $urandom(), $urandom()});
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 19) == 0) do_flush(1'($urandom_range(0, 1)), rand_addr());
         else do_req(rand_addr(), $urandom_range(0, 4), {$urandom(), $urandom(), $urandom(), $urandom()});
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
